wb_line_xfer: RTL
=================

# wb_line_xfer

Wishbone B4 burst master that moves one cache line between a cache controller and the simulation RAM slave. It accepts a line-refill or line-writeback request, issues a wrapping incrementing burst with correct CTI/BTE signalling, and streams refill words back critical-word-first. It sits directly upstream of the RAM slave's data port (dwbs_*).

## Interface
Parameters:
- LINE_WORDS, 8, words per line; legal values 4, 8, 16 (wrap4/8/16).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  line request present
- req_ready  out  1  block idle, can accept a request
- req_we  in  1  1 = writeback, 0 = refill
- req_addr  in  32  byte address; word-aligned, bits [1:0] ignored
- req_line  in  32*LINE_WORDS  writeback data, word i at [32*i+:32]; sampled at accept
- rsp_valid  out  1  one refill word valid
- rsp_idx  out  $clog2(LINE_WORDS)  word index within line
- rsp_data  out  32  refill word
- done  out  1  one-cycle pulse at end of transfer
- err  out  1  qualifies done: transfer aborted by wbm_err
- wbm_addr  out  32  Wishbone address
- wbm_dat_w  out  32  write data
- wbm_sel  out  4  byte selects, always 4'hF
- wbm_cyc / wbm_stb  out  1  cycle / strobe
- wbm_cti  out  3  cycle type
- wbm_bte  out  2  burst type
- wbm_we  out  1  write enable
- wbm_dat_r  in  32  read data
- wbm_ack  in  1  acknowledge
- wbm_err  in  1  error

## Operation
- FSM states: IDLE, BUS.
- IDLE: req_ready=1. req_valid&req_ready accepts; latch req_we, start address, req_line; go to BUS.
- Start address: refill uses req_addr word (critical word first). Writeback uses line base (req_addr with low $clog2(LINE_WORDS)+2 bits cleared).
- BUS: cyc=stb=1, we=latched req_we, sel=F, bte=01/10/11 for 4/8/16 words. cti=010 for beats 0..LINE_WORDS-2, 111 on the last beat.
- Beat counter counts acks from 0. On each ack, wbm_addr advances one word, wrapping inside the line (low index bits +1 mod LINE_WORDS, upper bits fixed). wbm_dat_w = latched word at the current index.
- Refill: each ack registers rsp_valid=1, rsp_data=wbm_dat_r, rsp_idx=the acked word's index.
- Last ack: go to IDLE; done pulses.
- wbm_err in BUS: go to IDLE; done=1 and err=1 the next cycle. No rsp_valid for the errored beat. Later beats are not issued.
- wbm_ack and wbm_err together: err wins.

## Timing
- Reset values: req_ready=1; rsp_valid, done, err, wbm_cyc, wbm_stb, wbm_we = 0; wbm_addr, wbm_dat_w, rsp_data = 0; rsp_idx=0; wbm_cti=000; wbm_bte=00; wbm_sel=F.
- Bus outputs are registered. cyc/stb assert the cycle after accept.
- The address is held stable until ack. Ack-free cycles are wait states, with no timeout.
- rsp_valid/rsp_data is one cycle after the corresponding ack. done coincides with the last rsp_valid (refill) or is one cycle after the last ack (writeback).
- cyc/stb deassert the cycle after the last ack or err. req_ready rises in that same cycle, so a back-to-back request is accepted then and its cyc/stb assert one cycle later (one idle bus cycle minimum).
- Reset mid-transfer: cyc/stb/we drop immediately (async), FSM goes to IDLE, no done is issued, and the latched request is discarded.

## Configuration
- WB_LINE_XFER_CLASSIC_EN defined: classic cycles only. cti=000, bte=00. cyc is held for the whole line. stb deasserts for one cycle after each ack, then reasserts with the next address.
- Undefined: incrementing wrapping bursts as described above.
- Done/rsp semantics are identical in both modes.

## Structure
- Shared package wb_pkg holds:
  - CTI_CLASSIC=000, CTI_INCR=010, CTI_END=111
  - BTE_LINEAR=00, BTE_WRAP4=01, BTE_WRAP8=10, BTE_WRAP16=11
  - the FSM state enum
  - a wrap-increment function (addr, bte)
- No sub-module. The beat counter and address wrap are inline.

## Test plan
- Refill, LINE_WORDS=8, req_addr=0x14, RAM slave with continuous acks:
  - addresses 0x14,0x18,0x1C,0x00,0x04,0x08,0x0C,0x10
  - cti 010×7 then 111, bte=10
  - rsp_idx 5,6,7,0,1,2,3,4, each rsp_data equal to the preloaded memory words
  - 8 acks on consecutive cycles, done with the 8th rsp
- Writeback req_addr=0x11C, req_line words 0xA0..0xA7:
  - burst starts at 0x100, we=1, sel=F
  - DPI reads of 0x100..0x11C return 0xA0..0xA7; done=1, err=0
- Slave acks only on alternate cycles: wbm_addr is unchanged across wait cycles, 8 rsp in 16 cycles, correct data.
- wbm_err on beat 3 of a refill:
  - rsp_valid for beats 0-2 only
  - cyc drops the next cycle
  - done=1, err=1
- rst asserted at beat 4:
  - cyc/stb go 0 in the same cycle, no done
  - after release, req_ready=1 and a new request completes normally
- WB_LINE_XFER_CLASSIC_EN build, refill at 0x20:
  - cti=000 on every beat
  - stb low one cycle between beats
  - 8 correct rsp words, done asserted

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 encodings, line-transfer FSM states and the
// wrap-increment helper used for burst address generation.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic {
        IDLE,
        BUS
    } state_t;

    // Bits inside the mask advance by one word; bits outside stay fixed.
    function automatic logic [31:0] wrap_inc(
        input logic [31:0] addr,
        input logic [1:0]  bte
    );
        logic [31:0] m;
        unique case (bte)
            BTE_WRAP4:  m = 32'h0000_000C;
            BTE_WRAP8:  m = 32'h0000_001C;
            BTE_WRAP16: m = 32'h0000_003C;
            default:    m = 32'hFFFF_FFFC;
        endcase
        return (addr & ~m) | ((addr + 32'd4) & m);
    endfunction

endpackage

// File: rtl/wb_line_xfer_if.sv
// Wishbone B4 master-side bus bundle for the line transfer block.
interface wb_line_xfer_if;

    logic [31:0] wbm_addr;
    logic [31:0] wbm_dat_w;
    logic [31:0] wbm_dat_r;
    logic [3:0]  wbm_sel;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic [2:0]  wbm_cti;
    logic [1:0]  wbm_bte;
    logic        wbm_we;
    logic        wbm_ack;
    logic        wbm_err;

    modport master (
        output wbm_addr, wbm_dat_w, wbm_sel, wbm_cyc, wbm_stb,
        output wbm_cti, wbm_bte, wbm_we,
        input  wbm_dat_r, wbm_ack, wbm_err
    );

    modport slave (
        input  wbm_addr, wbm_dat_w, wbm_sel, wbm_cyc, wbm_stb,
        input  wbm_cti, wbm_bte, wbm_we,
        output wbm_dat_r, wbm_ack, wbm_err
    );

endinterface

// File: rtl/wb_line_xfer.sv
// Cache line refill/writeback Wishbone burst master, critical word first.
// Define WB_LINE_XFER_CLASSIC_EN for classic single cycles instead of bursts.
module wb_line_xfer
    import wb_pkg::*;
#(
    parameter  int LINE_WORDS = 8,
    localparam int IW         = $clog2(LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [31:0]              req_addr,
    input  logic [32*LINE_WORDS-1:0] req_line,
    output logic                     rsp_valid,
    output logic [IW-1:0]            rsp_idx,
    output logic [31:0]              rsp_data,
    output logic                     done,
    output logic                     err,
    wb_line_xfer_if.master           wb
);

`ifdef WB_LINE_XFER_CLASSIC_EN
    localparam bit CLASSIC = 1'b1;
`else
    localparam bit CLASSIC = 1'b0;
`endif

    localparam logic [1:0] BTE_LINE =
        (LINE_WORDS == 4) ? BTE_WRAP4 :
        (LINE_WORDS == 8) ? BTE_WRAP8 : BTE_WRAP16;
    localparam logic [1:0]    BUS_BTE = CLASSIC ? BTE_LINEAR : BTE_LINE;
    localparam logic [IW-1:0] LAST    = IW'(LINE_WORDS - 1);
    localparam logic [31:0]   LMASK   = 32'(LINE_WORDS * 4 - 1);

    state_t                        state;
    logic                          we_q;
    logic [LINE_WORDS-1:0][31:0]   line_q;
    logic [IW-1:0]                 beat;
    logic [31:0]                   start;
    logic [31:0]                   nxt;
    logic [IW-1:0]                 start_idx;
    logic [IW-1:0]                 idx;
    logic [IW-1:0]                 nidx;
    logic                          ack;

    function automatic logic [2:0] cti_for(input logic [IW-1:0] b);
        if (CLASSIC) return CTI_CLASSIC;
        return (b == LAST) ? CTI_END : CTI_INCR;
    endfunction

    always_comb begin
        start     = req_we ? (req_addr & ~LMASK) : {req_addr[31:2], 2'b00};
        start_idx = start[IW+1:2];
        nxt       = wrap_inc(wb.wbm_addr, BTE_LINE);
        idx       = wb.wbm_addr[IW+1:2];
        nidx      = nxt[IW+1:2];
        ack       = wb.wbm_ack & wb.wbm_stb;
    end

    assign req_ready = (state == IDLE);
    assign wb.wbm_sel = 4'hF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            line_q       <= '0;
            beat         <= '0;
            rsp_valid    <= 1'b0;
            rsp_idx      <= '0;
            rsp_data     <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            wb.wbm_addr  <= '0;
            wb.wbm_dat_w <= '0;
            wb.wbm_cyc   <= 1'b0;
            wb.wbm_stb   <= 1'b0;
            wb.wbm_cti   <= CTI_CLASSIC;
            wb.wbm_bte   <= BTE_LINEAR;
            wb.wbm_we    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        state        <= BUS;
                        we_q         <= req_we;
                        line_q       <= req_line;
                        beat         <= '0;
                        wb.wbm_addr  <= start;
                        wb.wbm_dat_w <= req_line[32*start_idx +: 32];
                        wb.wbm_cyc   <= 1'b1;
                        wb.wbm_stb   <= 1'b1;
                        wb.wbm_we    <= req_we;
                        wb.wbm_cti   <= cti_for('0);
                        wb.wbm_bte   <= BUS_BTE;
                    end
                end
                BUS: begin
                    // err takes priority over a simultaneous ack
                    if (wb.wbm_err) begin
                        state      <= IDLE;
                        wb.wbm_cyc <= 1'b0;
                        wb.wbm_stb <= 1'b0;
                        wb.wbm_we  <= 1'b0;
                        wb.wbm_cti <= CTI_CLASSIC;
                        wb.wbm_bte <= BTE_LINEAR;
                        done       <= 1'b1;
                        err        <= 1'b1;
                    end else if (ack) begin
                        rsp_valid <= ~we_q;
                        rsp_data  <= wb.wbm_dat_r;
                        rsp_idx   <= idx;
                        if (beat == LAST) begin
                            state      <= IDLE;
                            wb.wbm_cyc <= 1'b0;
                            wb.wbm_stb <= 1'b0;
                            wb.wbm_we  <= 1'b0;
                            wb.wbm_cti <= CTI_CLASSIC;
                            wb.wbm_bte <= BTE_LINEAR;
                            done       <= 1'b1;
                        end else begin
                            beat         <= beat + IW'(1);
                            wb.wbm_addr  <= nxt;
                            wb.wbm_dat_w <= line_q[nidx];
                            wb.wbm_cti   <= cti_for(beat + IW'(1));
                            if (CLASSIC) wb.wbm_stb <= 1'b0;
                        end
                    end else if (!wb.wbm_stb) begin
                        wb.wbm_stb <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
